word_match_engine: RTL and testbench

//  Parametrised next-generation letter matcher for the Morse decoder game.

---
 rtl/word_match_pkg.sv | 35 +++
 rtl/word_match_engine_if.sv | 38 +++
 rtl/word_rom.sv | 27 ++
 rtl/word_match_engine.sv | 137 +++++++++++++
 tb/tb_word_match_engine.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/word_match_pkg.sv
// Shared types and constants for the Morse game letter matcher: FSM states,
// ASCII helpers and the fixed word bank.
package word_match_pkg;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam int MAX_WORD_LEN = 8;
  localparam int BANK_SIZE    = 4;
  localparam int BANK_W       = 2;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Character 0 of each word is the leftmost byte of the string literal.
  localparam logic [8*MAX_WORD_LEN-1:0] WORD_BANK [BANK_SIZE] = '{
    "HELLO   ",
    "MORSE   ",
    "RADIO   ",
    "CODES   "
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= ASCII_LC_A && c <= ASCII_LC_Z) return c - ASCII_CASE_OFS;
    return c;
  endfunction

endpackage

// File: rtl/word_match_engine_if.sv
// Signal bundle between the Morse decoder / display drivers and the matcher.
// The engine has no handshake: a commit is the rising edge of PlayerBtn and
// every result is a registered level or a one-cycle pulse.
interface word_match_engine_if
  import word_match_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 4,
  parameter int SCORE_W   = 8
);
  localparam int IDX_W = idx_width(NUM_WORDS);

  logic                PlayerBtn;
  logic [7:0]          ASCIIInput;
  logic [1:0]          mode;
  logic                timeout;
  logic [WORD_LEN-1:0] letter_leds;
  logic [SCORE_W-1:0]  points;
  logic [SCORE_W-1:0]  high_score;
  logic [2:0]          lives_left;
  logic [IDX_W-1:0]    word_idx;
  logic                word_done;
  logic                mismatch;
  logic                game_over;
  state_e              state_dbg;

  modport master (
    output PlayerBtn, ASCIIInput, mode, timeout,
    input  letter_leds, points, high_score, lives_left, word_idx,
    input  word_done, mismatch, game_over, state_dbg
  );

  modport slave (
    input  PlayerBtn, ASCIIInput, mode, timeout,
    output letter_leds, points, high_score, lives_left, word_idx,
    output word_done, mismatch, game_over, state_dbg
  );
endinterface

// File: rtl/word_rom.sv
// Combinational word bank lookup: (word index, letter position) -> ASCII char.
// Word indices beyond the bank size wrap onto the bank.
module word_rom
  import word_match_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 4,
  localparam int IDX_W    = idx_width(NUM_WORDS),
  localparam int POS_W    = idx_width(WORD_LEN)
) (
  input  logic [IDX_W-1:0] word_idx_i,
  input  logic [POS_W-1:0] pos_i,
  output logic [7:0]       char_o
);

  logic [BANK_W-1:0] bank_sel;

  assign bank_sel = BANK_W'(word_idx_i);

  always_comb begin
    char_o = 8'h00;
    for (int p = 0; p < WORD_LEN; p++) begin
      if (pos_i == POS_W'(p)) char_o = WORD_BANK[bank_sel][8*(MAX_WORD_LEN-1-p) +: 8];
    end
  end

endmodule

// File: rtl/word_match_engine.sv
// Letter matcher for the Morse decoder game: compares committed letters with the
// word bank and tracks progress LEDs, score, high score and lives.
module word_match_engine
  import word_match_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 4,
  parameter int SCORE_W   = 8,
  parameter int LIVES     = 3
) (
  input  logic                clk,
  input  logic                rst,
  word_match_engine_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_WORDS);
  localparam int POS_W = idx_width(WORD_LEN);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_e              state_q, state_d;
  logic                btn_q;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [WORD_LEN-1:0] leds_q, leds_d;
  logic [SCORE_W-1:0]  points_q, points_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic [2:0]          lives_q, lives_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                mis_q, mis_d;

  logic                press;
  logic [7:0]          rom_char;
  logic [7:0]          cmp_char;
  logic                hit;
  logic                last_pos;
  logic [IDX_W-1:0]    idx_next;

  word_rom #(
    .WORD_LEN  (WORD_LEN),
    .NUM_WORDS (NUM_WORDS)
  ) u_rom (
    .word_idx_i (idx_q),
    .pos_i      (pos_q),
    .char_o     (rom_char)
  );

  assign press    = bus.PlayerBtn & ~btn_q;
  assign cmp_char = bus.mode[0] ? fold_case(bus.ASCIIInput) : bus.ASCIIInput;
  assign hit      = (cmp_char == rom_char);
  assign last_pos = (pos_q == POS_W'(WORD_LEN-1));
  assign idx_next = (idx_q == IDX_W'(NUM_WORDS-1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    leds_d   = leds_q;
    points_d = points_q;
    lives_d  = lives_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    unique case (state_q)
      PLAY: begin
        // A timeout wins over a press landing in the same cycle.
        if (bus.timeout || (press && !hit)) begin
          mis_d  = 1'b1;
          leds_d = '0;
          pos_d  = '0;
          if (!bus.mode[1]) begin
            lives_d = lives_q - 3'd1;
            if (lives_d == 3'd0) state_d = OVER;
          end
        end else if (press) begin
          if (!last_pos) begin
            leds_d = leds_q | (WORD_LEN'(1) << pos_q);
            pos_d  = pos_q + 1'b1;
          end else begin
            done_d = 1'b1;
            leds_d = '0;
            pos_d  = '0;
            idx_d  = idx_next;
            if (!bus.mode[1] && (points_q != '1)) points_d = points_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (press) begin
          state_d  = PLAY;
          points_d = '0;
          lives_d  = LIVES_INIT;
          idx_d    = '0;
          pos_d    = '0;
          leds_d   = '0;
        end
      end
      default: state_d = PLAY;
    endcase
    high_d = (points_d > high_q) ? points_d : high_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PLAY;
      btn_q    <= 1'b0;
      pos_q    <= '0;
      leds_q   <= '0;
      points_q <= '0;
      high_q   <= '0;
      lives_q  <= LIVES_INIT;
      idx_q    <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= bus.PlayerBtn;
      pos_q    <= pos_d;
      leds_q   <= leds_d;
      points_q <= points_d;
      high_q   <= high_d;
      lives_q  <= lives_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.letter_leds = leds_q;
  assign bus.points      = points_q;
  assign bus.high_score  = high_q;
  assign bus.lives_left  = lives_q;
  assign bus.word_idx    = idx_q;
  assign bus.word_done   = done_q;
  assign bus.mismatch    = mis_q;
  assign bus.game_over   = (state_q == OVER);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_word_match_engine.sv
// Bench for word_match_engine (WORD_LEN=5, NUM_WORDS=4, SCORE_W=2, LIVES=3):
// a table of commits with hand-derived results, plus held-button and async reset sequences.
module tb_word_match_engine;

  localparam int OBS_W = 17;
  localparam int K_PRESS = 0;
  localparam int K_TMO   = 1;
  localparam int K_BOTH  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_match_engine_if #(.WORD_LEN(5), .NUM_WORDS(4), .SCORE_W(2)) bus ();

  word_match_engine #(
    .WORD_LEN  (5),
    .NUM_WORDS (4),
    .SCORE_W   (2),
    .LIVES     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         kind;
    logic [7:0] ch;
    logic [1:0] mode;
    logic [4:0] leds;
    logic [1:0] pts;
    logic [1:0] hi;
    logic [2:0] lives;
    logic [1:0] idx;
    logic       done;
    logic       mis;
    logic       over;
  } vec_t;

  vec_t             vecs[$];
  logic [OBS_W-1:0] exp_q[$];
  int               total = 0;
  int               bad   = 0;

  function automatic logic [OBS_W-1:0] pack_exp(input vec_t v, input logic pulses);
    return {v.leds, v.pts, v.hi, v.lives, v.idx, v.done & pulses, v.mis & pulses, v.over};
  endfunction

  function logic [OBS_W-1:0] observe();
    return {bus.letter_leds, bus.points, bus.high_score, bus.lives_left, bus.word_idx,
            bus.word_done, bus.mismatch, bus.game_over};
  endfunction

  task automatic add(input int kind, input logic [7:0] ch, input logic [1:0] mode,
                     input logic [4:0] leds, input logic [1:0] pts, input logic [1:0] hi,
                     input logic [2:0] lives, input logic [1:0] idx,
                     input logic done, input logic mis, input logic over);
    vec_t v;
    v.kind = kind; v.ch = ch; v.mode = mode; v.leds = leds; v.pts = pts; v.hi = hi;
    v.lives = lives; v.idx = idx; v.done = done; v.mis = mis; v.over = over;
    vecs.push_back(v);
  endtask

  task automatic check_now(input string name);
    logic [OBS_W-1:0] exp_v;
    logic [OBS_W-1:0] got_v;
    exp_v = exp_q.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%b exp=%b (leds,pts,hi,lives,idx,done,mis,over)", name, got_v, exp_v);
    end
  endtask

  // Called at a negedge: drive, let one posedge register it, check at the next negedge.
  task automatic drive_cycle(input logic btn, input logic [7:0] ch, input logic [1:0] mode,
                             input logic tmo, input logic [OBS_W-1:0] exp_v, input string name);
    bus.PlayerBtn  = btn;
    bus.ASCIIInput = ch;
    bus.mode       = mode;
    bus.timeout    = tmo;
    exp_q.push_back(exp_v);
    @(posedge clk);
    @(negedge clk);
    check_now(name);
  endtask

  task automatic fill_table();
    add(K_PRESS,  72, 2'b00, 5'b00001, 0, 0, 3, 0, 0, 0, 0);
    add(K_PRESS,  69, 2'b00, 5'b00011, 0, 0, 3, 0, 0, 0, 0);
    add(K_PRESS,  76, 2'b00, 5'b00111, 0, 0, 3, 0, 0, 0, 0);
    add(K_PRESS,  76, 2'b00, 5'b01111, 0, 0, 3, 0, 0, 0, 0);
    add(K_PRESS,  79, 2'b00, 5'b00000, 1, 1, 3, 1, 1, 0, 0);
    add(K_PRESS,  77, 2'b00, 5'b00001, 1, 1, 3, 1, 0, 0, 0);
    add(K_PRESS,  79, 2'b00, 5'b00011, 1, 1, 3, 1, 0, 0, 0);
    add(K_PRESS,  82, 2'b00, 5'b00111, 1, 1, 3, 1, 0, 0, 0);
    add(K_PRESS,  83, 2'b00, 5'b01111, 1, 1, 3, 1, 0, 0, 0);
    add(K_PRESS,  69, 2'b00, 5'b00000, 2, 2, 3, 2, 1, 0, 0);
    add(K_PRESS,  82, 2'b00, 5'b00001, 2, 2, 3, 2, 0, 0, 0);
    add(K_PRESS,  88, 2'b00, 5'b00000, 2, 2, 2, 2, 0, 1, 0);
    add(K_PRESS, 114, 2'b01, 5'b00001, 2, 2, 2, 2, 0, 0, 0);
    add(K_PRESS,  97, 2'b01, 5'b00011, 2, 2, 2, 2, 0, 0, 0);
    add(K_PRESS, 100, 2'b01, 5'b00111, 2, 2, 2, 2, 0, 0, 0);
    add(K_PRESS, 105, 2'b01, 5'b01111, 2, 2, 2, 2, 0, 0, 0);
    add(K_PRESS, 111, 2'b01, 5'b00000, 3, 3, 2, 3, 1, 0, 0);
    add(K_PRESS,  99, 2'b10, 5'b00000, 3, 3, 2, 3, 0, 1, 0);
    add(K_BOTH,   67, 2'b00, 5'b00000, 3, 3, 1, 3, 0, 1, 0);
    add(K_TMO,     0, 2'b00, 5'b00000, 3, 3, 0, 3, 0, 1, 1);
    add(K_TMO,     0, 2'b00, 5'b00000, 3, 3, 0, 3, 0, 0, 1);
    add(K_PRESS,  90, 2'b00, 5'b00000, 0, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  81, 2'b10, 5'b00000, 0, 3, 3, 0, 0, 1, 0);
    add(K_PRESS,  72, 2'b10, 5'b00001, 0, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  69, 2'b10, 5'b00011, 0, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  76, 2'b10, 5'b00111, 0, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  76, 2'b10, 5'b01111, 0, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  79, 2'b10, 5'b00000, 0, 3, 3, 1, 1, 0, 0);
    add(K_PRESS,  77, 2'b00, 5'b00001, 0, 3, 3, 1, 0, 0, 0);
    add(K_PRESS, 111, 2'b01, 5'b00011, 0, 3, 3, 1, 0, 0, 0);
    add(K_PRESS,  82, 2'b00, 5'b00111, 0, 3, 3, 1, 0, 0, 0);
    add(K_PRESS,  83, 2'b00, 5'b01111, 0, 3, 3, 1, 0, 0, 0);
    add(K_PRESS,  69, 2'b00, 5'b00000, 1, 3, 3, 2, 1, 0, 0);
    add(K_PRESS,  82, 2'b00, 5'b00001, 1, 3, 3, 2, 0, 0, 0);
    add(K_PRESS,  65, 2'b00, 5'b00011, 1, 3, 3, 2, 0, 0, 0);
    add(K_PRESS,  68, 2'b00, 5'b00111, 1, 3, 3, 2, 0, 0, 0);
    add(K_PRESS,  73, 2'b00, 5'b01111, 1, 3, 3, 2, 0, 0, 0);
    add(K_PRESS,  79, 2'b00, 5'b00000, 2, 3, 3, 3, 1, 0, 0);
    add(K_PRESS,  67, 2'b00, 5'b00001, 2, 3, 3, 3, 0, 0, 0);
    add(K_PRESS,  79, 2'b00, 5'b00011, 2, 3, 3, 3, 0, 0, 0);
    add(K_PRESS,  68, 2'b00, 5'b00111, 2, 3, 3, 3, 0, 0, 0);
    add(K_PRESS,  69, 2'b00, 5'b01111, 2, 3, 3, 3, 0, 0, 0);
    add(K_PRESS,  83, 2'b00, 5'b00000, 3, 3, 3, 0, 1, 0, 0);
    add(K_PRESS,  72, 2'b00, 5'b00001, 3, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  69, 2'b00, 5'b00011, 3, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  76, 2'b00, 5'b00111, 3, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  76, 2'b00, 5'b01111, 3, 3, 3, 0, 0, 0, 0);
    add(K_PRESS,  79, 2'b00, 5'b00000, 3, 3, 3, 1, 1, 0, 0);
  endtask

  initial begin
    vec_t             v;
    vec_t             rv;
    logic [OBS_W-1:0] reset_obs;

    rst            = 1'b0;
    bus.PlayerBtn  = 1'b0;
    bus.ASCIIInput = 8'h00;
    bus.mode       = 2'b00;
    bus.timeout    = 1'b0;
    rv.kind = K_PRESS; rv.ch = 8'h00; rv.mode = 2'b00; rv.leds = 5'b0; rv.pts = 2'd0;
    rv.hi = 2'd0; rv.lives = 3'd3; rv.idx = 2'd0; rv.done = 1'b0; rv.mis = 1'b0; rv.over = 1'b0;
    reset_obs = pack_exp(rv, 1'b0);

    repeat (3) @(negedge clk);
    exp_q.push_back(reset_obs);
    check_now("reset_values");
    rst = 1'b1;
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, reset_obs, "idle_after_reset");

    fill_table();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_cycle(v.kind != K_TMO, v.ch, v.mode, v.kind != K_PRESS, pack_exp(v, 1'b1),
                  $sformatf("row%0d", i));
      drive_cycle(1'b0, v.ch, v.mode, 1'b0, pack_exp(v, 1'b0), $sformatf("row%0d_hold", i));
    end

    // Word 1 is "MORSE": a held 'M' must commit once, then 'O' continues the word.
    v.leds = 5'b00001; v.pts = 2'd3; v.hi = 2'd3; v.lives = 3'd3; v.idx = 2'd1;
    v.done = 1'b0; v.mis = 1'b0; v.over = 1'b0;
    for (int c = 0; c < 10; c++)
      drive_cycle(1'b1, 8'd77, 2'b00, 1'b0, pack_exp(v, 1'b0), $sformatf("held_btn_c%0d", c));
    drive_cycle(1'b0, 8'd77, 2'b00, 1'b0, pack_exp(v, 1'b0), "held_btn_release");
    v.leds = 5'b00011;
    drive_cycle(1'b1, 8'd79, 2'b00, 1'b0, pack_exp(v, 1'b0), "after_hold_next");
    drive_cycle(1'b0, 8'd79, 2'b00, 1'b0, pack_exp(v, 1'b0), "after_hold_release");

    // Reset mid-word, between clock edges: outputs must clear without waiting for a clock.
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(reset_obs);
    check_now("async_reset_midword");
    @(negedge clk);
    rst = 1'b1;
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, reset_obs, "after_async_reset");
    rv.leds = 5'b00001;
    drive_cycle(1'b1, 8'd72, 2'b00, 1'b0, pack_exp(rv, 1'b0), "restart_word0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
